// File: rtl/mips_bus_pkg.sv
// Shared definitions for the data-memory / MMIO bus arbiter.
// Holds the arbiter state encoding, default bus widths and the requester-count
// ceiling. The top-level arbiter honours the optional macro ARB_TIMEOUT_EN.
package mips_bus_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 32;
   localparam int NREQ_MAX = 4;

   // Index width for a vector of n entries (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// by a cyclic search that starts at ptr_i and wraps from N-1 back to 0.
module rr_pick
   import mips_bus_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   int            cand;
   logic [IW-1:0] cand_idx;

   // Walk offsets 0..N-1 from the pointer; the first hit wins.
   always_comb begin
      valid_o  = 1'b0;
      idx_o    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 0; off < N; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared data-memory / MMIO bus.
// Port 0 is the datapath load/store port, the others are DMA/debug masters.
// A grant is registered; while granted the owner's request is acked
// combinationally and one transfer completes per cycle. Locked bursts keep the
// grant. Release always passes through one IDLE cycle.
// Optional macro ARB_TIMEOUT_EN bounds locked bursts to TIMEOUT cycles and
// pulses timeout_err on a forced release.
module mem_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   lock,
   input  logic [NREQ-1:0]   we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [DW-1:0]     rdata,
   output logic [AW-1:0]     bus_addr,
   output logic [DW-1:0]     bus_wdata,
   output logic              bus_we,
   input  logic [DW-1:0]     bus_rdata,
   output logic              timeout_err
);

   localparam int IW = idx_w(NREQ);

   // Elaboration-time guard on the configuration.
   if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 2) begin : g_param_check
      $error("mem_bus_arbiter: unsupported NREQ or TIMEOUT");
   end

   arb_state_e    state_q,  state_d;
   logic [IW-1:0] owner_q,  owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          owner_req;
   logic          owner_lock;
   logic          release_now;
   logic [IW-1:0] ptr_after_owner;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = idx_w(TIMEOUT);
   localparam logic [CW-1:0] LOCK_LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          tmo_q,      tmo_d;
`endif

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign owner_req       = req[owner_q];
   assign owner_lock      = lock[owner_q];
   // The released owner gets the lowest priority in the next search.
   assign ptr_after_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

   // State register: FSM state, current owner and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Locked-burst length counter and the forced-release pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         tmo_q      <= tmo_d;
      end
   end
`endif

   // Next-state logic: arbitrate in IDLE, hold or release in BUSY.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
      lock_cnt_d  = lock_cnt_q;
      tmo_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_BUSY;
               owner_d = pick_idx;
            end
         end
         ST_BUSY: begin
            if (owner_req && owner_lock) begin
`ifdef ARB_TIMEOUT_EN
               if (lock_cnt_q == LOCK_LIMIT) begin
                  release_now = 1'b1;
                  tmo_d       = 1'b1;
               end else begin
                  lock_cnt_d = lock_cnt_q + CW'(1);
               end
`endif
            end else begin
               release_now = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (release_now) begin
         state_d  = ST_IDLE;
         rr_ptr_d = ptr_after_owner;
`ifdef ARB_TIMEOUT_EN
         lock_cnt_d = '0;
`endif
      end
   end

   // Output logic: grant/ack vectors and the owner's bus signals.
   always_comb begin
      gnt       = '0;
      ack       = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_we    = 1'b0;
      rdata     = '0;
      if (state_q == ST_BUSY) begin
         for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
               gnt[i]    = 1'b1;
               ack[i]    = req[i];
               bus_addr  = addr[i*AW +: AW];
               bus_wdata = wdata[i*DW +: DW];
               bus_we    = we[i] & req[i] & ~reset;
            end
         end
         rdata = bus_rdata;
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NREQ=2). Inputs change 1 ns after the
// rising edge, outputs are checked on the falling edge.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  lock;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic [31:0] bus_rdata;
   logic        timeout_err;

   int total;
   int bad;

   mem_bus_arbiter #(
      .NREQ    (2),
      .DW      (32),
      .AW      (32),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .lock        (lock),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt),
      .ack         (ack),
      .rdata       (rdata),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_we      (bus_we),
      .bus_rdata   (bus_rdata),
      .timeout_err (timeout_err)
   );

   // Clock and run-time bound.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [1:0]  exp_gnt [6];
   logic [31:0] exp_adr [6];

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      req       = '0;
      lock      = '0;
      we        = '0;
      addr      = '0;
      wdata     = '0;
      bus_rdata = '0;
      exp_gnt   = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      exp_adr   = '{32'h200, 32'h0, 32'h100, 32'h0, 32'h200, 32'h0};

      repeat (2) @(posedge clk);
      #1;

      // Single read by requester 0.
      reset            = 1'b0;
      req              = 2'b01;
      addr[0*32 +: 32] = 32'h10;
      bus_rdata        = 32'hCAFE0001;
      sample();
      check("rst_gnt", gnt, 2'b00);
      check("rst_ack", ack, 2'b00);
      check("rst_bus_we", bus_we, 1'b0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_tmo", timeout_err, 1'b0);

      tick();
      sample();
      check("rd_gnt", gnt, 2'b01);
      check("rd_ack", ack, 2'b01);
      check("rd_rdata", rdata, 32'hCAFE0001);
      check("rd_bus_addr", bus_addr, 32'h10);
      check("rd_bus_we", bus_we, 1'b0);

      tick();
      req = 2'b00;
      sample();
      check("rd_release_gnt", gnt, 2'b00);
      check("rd_release_ack", ack, 2'b00);

      // Both request continuously without lock: grants alternate with an
      // IDLE cycle between them; pointer is 1 after the first grant.
      tick();
      req              = 2'b11;
      addr[0*32 +: 32] = 32'h100;
      addr[1*32 +: 32] = 32'h200;
      sample();
      check("alt_idle_gnt", gnt, 2'b00);
      for (int k = 0; k < 6; k++) begin
         tick();
         sample();
         check($sformatf("alt_gnt_%0d", k), gnt, exp_gnt[k]);
         check($sformatf("alt_ack_%0d", k), ack, exp_gnt[k]);
         check($sformatf("alt_addr_%0d", k), bus_addr, exp_adr[k]);
      end

      // Owner 0 drops its request in its granted cycle: no ack, no write.
      tick();
      req = 2'b00;
      we  = 2'b11;
      sample();
      check("drop_gnt", gnt, 2'b01);
      check("drop_ack", ack, 2'b00);
      check("drop_bus_we", bus_we, 1'b0);

      // Locked write burst by requester 1 while requester 0 waits.
      tick();
      req               = 2'b11;
      lock              = 2'b10;
      we                = 2'b10;
      addr[1*32 +: 32]  = 32'h20;
      wdata[1*32 +: 32] = 32'hD0;
      sample();
      check("drop_release_gnt", gnt, 2'b00);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            tick();
            addr[1*32 +: 32]  = 32'h20 + 32'(4 * k);
            wdata[1*32 +: 32] = 32'hD0 + 32'(k);
            if (k == 3) lock = 2'b00;
         end else begin
            tick();
         end
         sample();
         check($sformatf("burst_gnt_%0d", k), gnt, 2'b10);
         check($sformatf("burst_ack_%0d", k), ack, 2'b10);
         check($sformatf("burst_we_%0d", k), bus_we, 1'b1);
         check($sformatf("burst_addr_%0d", k), bus_addr, 32'h20 + 32'(4 * k));
         check($sformatf("burst_wdata_%0d", k), bus_wdata, 32'hD0 + 32'(k));
      end

      tick();
      req = 2'b01;
      we  = 2'b00;
      sample();
      check("burst_end_gnt", gnt, 2'b00);
      check("burst_end_ack", ack, 2'b00);

      tick();
      sample();
      check("waiter_gnt", gnt, 2'b01);
      check("waiter_ack", ack, 2'b01);
      check("waiter_addr", bus_addr, 32'h100);

      // Reset in the middle of a locked write burst.
      tick();
      req = 2'b00;
      sample();
      check("pre_rst_idle_gnt", gnt, 2'b00);

      tick();
      req               = 2'b10;
      lock              = 2'b10;
      we                = 2'b10;
      addr[1*32 +: 32]  = 32'h40;
      wdata[1*32 +: 32] = 32'h55;
      sample();
      check("pre_rst_arb_gnt", gnt, 2'b00);

      tick();
      sample();
      check("pre_rst_gnt", gnt, 2'b10);
      check("pre_rst_bus_we", bus_we, 1'b1);
      check("pre_rst_addr", bus_addr, 32'h40);

      tick();
      reset = 1'b1;
      sample();
      check("rst_cycle_bus_we", bus_we, 1'b0);

      tick();
      sample();
      check("post_rst_gnt", gnt, 2'b00);
      check("post_rst_ack", ack, 2'b00);
      check("post_rst_bus_we", bus_we, 1'b0);
      check("post_rst_addr", bus_addr, 32'h0);
      check("post_rst_wdata", bus_wdata, 32'h0);
      check("post_rst_tmo", timeout_err, 1'b0);

      tick();
      reset = 1'b0;
      req   = 2'b00;
      lock  = 2'b00;
      we    = 2'b00;
      sample();
      check("post_rst_idle_gnt", gnt, 2'b00);

      // Requester 0 holds a lock indefinitely while requester 1 waits.
      tick();
      req              = 2'b11;
      lock             = 2'b01;
      addr[0*32 +: 32] = 32'h300;
      sample();
      check("lock0_idle_gnt", gnt, 2'b00);

`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         tick();
         sample();
         check($sformatf("tmo_gnt_%0d", k), gnt, 2'b01);
         check($sformatf("tmo_ack_%0d", k), ack, 2'b01);
         check($sformatf("tmo_err_%0d", k), timeout_err, 1'b0);
      end
      tick();
      sample();
      check("tmo_release_gnt", gnt, 2'b00);
      check("tmo_release_ack", ack, 2'b00);
      check("tmo_pulse", timeout_err, 1'b1);

      tick();
      sample();
      check("tmo_next_gnt", gnt, 2'b10);
      check("tmo_next_ack", ack, 2'b10);
      check("tmo_pulse_end", timeout_err, 1'b0);
`else
      for (int k = 0; k < 20; k++) begin
         tick();
         sample();
         check($sformatf("lock_hold_gnt_%0d", k), gnt, 2'b01);
         check($sformatf("lock_hold_ack_%0d", k), ack, 2'b01);
         check($sformatf("lock_hold_tmo_%0d", k), timeout_err, 1'b0);
      end
`endif

      tick();
      req  = 2'b00;
      lock = 2'b00;
      tick();
      tick();
      sample();
      check("final_idle_gnt", gnt, 2'b00);
      check("final_idle_ack", ack, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
